// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register for the pipelined SCPU.
// Registers decoded operands and control, resolves the destination register,
// applies WB->ID bypass at capture and MEM/WB->EX forwarding on the registered
// operands, selects the ALU B operand and flags load-use hazards.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   flush                     squash the instruction entering EX
//   id_*                      decoded instruction, register-file data, control
//   mem_regwrite/a3/result    instruction currently in MEM
//   wb_regwrite/a3/rfwd       instruction currently in WB
//   stall                     load-use hazard, PC and IF/ID hold (combinational)
//   ex_valid/regwrite/memread registered EX control
//   ex_a3                     registered destination register
//   ex_a, ex_b, ex_store_data forwarded ALU operands and store data
module id_ex_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_rt_used,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm32,
    input  logic [DATA_W-1:0] id_sha32,
    input  logic [1:0]        id_alusrc,
    input  logic [1:0]        id_regdst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              mem_regwrite,
    input  logic [RA_W-1:0]   mem_a3,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [RA_W-1:0]   wb_a3,
    input  logic [DATA_W-1:0] wb_rfwd,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [RA_W-1:0]   ex_a3,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data
);

    // Control encodings shared with the decoder (ctrl_encode_def.v).
    localparam logic [1:0] ALUSRC_REG  = 2'd0;
    localparam logic [1:0] ALUSRC_IMM  = 2'd1;
    localparam logic [1:0] ALUSRC_SHA  = 2'd2;
    localparam logic [1:0] RD_RT       = 2'd0;
    localparam logic [1:0] RD_RD       = 2'd1;
    localparam logic [1:0] RD_RA       = 2'd2;
    localparam logic [RA_W-1:0] LINK_REG = '1;

    logic [RA_W-1:0]   dest_sel;
    logic [DATA_W-1:0] rs_byp;
    logic [DATA_W-1:0] rt_byp;
    logic              wb_hits_rs;
    logic              wb_hits_rt;

    // Registered operand state that feeds the EX forwarding muxes.
    logic [RA_W-1:0]   ex_rs;
    logic [RA_W-1:0]   ex_rt;
    logic [DATA_W-1:0] ex_rs_val;
    logic [DATA_W-1:0] ex_rt_val;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_sha;
    logic [1:0]        ex_alusrc;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Destination select; unknown codes fall back to rt.
    always_comb begin
        dest_sel = id_rt;
        case (id_regdst)
            RD_RT:   dest_sel = id_rt;
            RD_RD:   dest_sel = id_rd;
            RD_RA:   dest_sel = LINK_REG;
            default: dest_sel = id_rt;
        endcase
    end

    // WB->ID bypass: the register file is written this same edge, so its read
    // data is still stale.
    always_comb begin
        wb_hits_rs = wb_regwrite && (wb_a3 != '0) && (wb_a3 == id_rs);
        wb_hits_rt = wb_regwrite && (wb_a3 != '0) && (wb_a3 == id_rt);
        rs_byp     = wb_hits_rs ? wb_rfwd : id_rd1;
        rt_byp     = wb_hits_rt ? wb_rfwd : id_rd2;
    end

    // Load-use hazard: a load in EX whose result the ID instruction needs.
    always_comb begin
        stall = ex_valid && ex_memread && (ex_a3 != '0) && id_valid &&
                ((ex_a3 == id_rs) || (id_rt_used && (ex_a3 == id_rt)));
    end

    // EX register; flush and stall both insert a zeroed bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_a3       <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rs_val   <= '0;
            ex_rt_val   <= '0;
            ex_imm      <= '0;
            ex_sha      <= '0;
            ex_alusrc   <= ALUSRC_REG;
        end else if (flush || stall) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_a3       <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rs_val   <= '0;
            ex_rt_val   <= '0;
            ex_imm      <= '0;
            ex_sha      <= '0;
            ex_alusrc   <= ALUSRC_REG;
        end else begin
            ex_valid    <= id_valid;
            ex_regwrite <= id_regwrite && id_valid;
            ex_memread  <= id_memread && id_valid;
            ex_a3       <= dest_sel;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rs_val   <= rs_byp;
            ex_rt_val   <= rt_byp;
            ex_imm      <= id_imm32;
            ex_sha      <= id_sha32;
            ex_alusrc   <= id_alusrc;
        end
    end

    // EX forwarding, MEM before WB; register 0 never forwards.
    always_comb begin
        fwd_rs = ex_rs_val;
        fwd_rt = ex_rt_val;
        if (mem_regwrite && (mem_a3 != '0) && (mem_a3 == ex_rs)) begin
            fwd_rs = mem_result;
        end else if (wb_regwrite && (wb_a3 != '0) && (wb_a3 == ex_rs)) begin
            fwd_rs = wb_rfwd;
        end
        if (mem_regwrite && (mem_a3 != '0) && (mem_a3 == ex_rt)) begin
            fwd_rt = mem_result;
        end else if (wb_regwrite && (wb_a3 != '0) && (wb_a3 == ex_rt)) begin
            fwd_rt = wb_rfwd;
        end
    end

    // ALU operand selection.
    always_comb begin
        ex_a          = fwd_rs;
        ex_store_data = fwd_rt;
        ex_b          = '0;
        case (ex_alusrc)
            ALUSRC_REG: ex_b = fwd_rt;
            ALUSRC_IMM: ex_b = ex_imm;
            ALUSRC_SHA: ex_b = ex_sha;
            default:    ex_b = '0;
        endcase
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized scoreboard bench for id_ex_operand_stage: a driver issues one
// instruction per cycle and pushes the expected EX-stage view into a queue, a
// monitor pops and compares every cycle.
module tb_id_ex_operand_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int NCYC = 3000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic          id_rt_used = 1'b0;
    logic [DW-1:0] id_rd1 = '0, id_rd2 = '0, id_imm32 = '0, id_sha32 = '0;
    logic [1:0]    id_alusrc = '0, id_regdst = '0;
    logic          id_regwrite = 1'b0, id_memread = 1'b0;
    logic          mem_regwrite = 1'b0;
    logic [AW-1:0] mem_a3 = '0;
    logic [DW-1:0] mem_result = '0;
    logic          wb_regwrite = 1'b0;
    logic [AW-1:0] wb_a3 = '0;
    logic [DW-1:0] wb_rfwd = '0;
    logic          stall;
    logic          ex_valid, ex_regwrite, ex_memread;
    logic [AW-1:0] ex_a3;
    logic [DW-1:0] ex_a, ex_b, ex_store_data;

    id_ex_operand_stage #(.DATA_W(DW), .RA_W(AW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rt_used(id_rt_used),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm32(id_imm32), .id_sha32(id_sha32),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .mem_regwrite(mem_regwrite), .mem_a3(mem_a3), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_a3(wb_a3), .wb_rfwd(wb_rfwd),
        .stall(stall), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_a3(ex_a3), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    // The instruction the model believes is sitting in EX.
    typedef struct {
        logic          valid, regwrite, memread;
        logic [AW-1:0] a3, rs, rt;
        logic [DW-1:0] rs_val, rt_val, imm, sha;
        logic [1:0]    alusrc;
    } instr_t;

    typedef struct {
        logic          stall, valid, regwrite, memread;
        logic [AW-1:0] a3;
        logic [DW-1:0] a, b, sd;
    } exp_t;

    exp_t   sb[$];
    instr_t cur;
    int     n_tests = 0;
    int     n_fail  = 0;

    function automatic instr_t bubble();
        instr_t r;
        r.valid = 0; r.regwrite = 0; r.memread = 0;
        r.a3 = '0; r.rs = '0; r.rt = '0;
        r.rs_val = '0; r.rt_val = '0; r.imm = '0; r.sha = '0; r.alusrc = 2'd0;
        return r;
    endfunction

    // Newest in-flight producer of register r wins; r0 is always architectural.
    function automatic logic [DW-1:0] newest(input logic [AW-1:0] r, input logic [DW-1:0] v,
                                             input logic use_mem);
        if (r == 0) return v;
        if (use_mem && mem_regwrite && mem_a3 == r) return mem_result;
        if (wb_regwrite && wb_a3 == r) return wb_rfwd;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares one expectation per cycle, away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("stall",         DW'(stall),       DW'(e.stall));
                check("ex_valid",      DW'(ex_valid),    DW'(e.valid));
                check("ex_regwrite",   DW'(ex_regwrite), DW'(e.regwrite));
                check("ex_memread",    DW'(ex_memread),  DW'(e.memread));
                check("ex_a3",         DW'(ex_a3),       DW'(e.a3));
                check("ex_a",          ex_a,             e.a);
                check("ex_b",          ex_b,             e.b);
                check("ex_store_data", ex_store_data,    e.sd);
            end
        end
    end

    function automatic logic [AW-1:0] rnd_reg();
        if ($urandom_range(0, 15) == 0) return AW'(31);
        return AW'($urandom_range(0, 7));
    endfunction

    // Driver and reference model.
    initial begin
        exp_t e;
        instr_t nxt;
        logic hz;
        cur = bubble();
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            rstn = !((c < 3) || (c == 1500) || (c == 1501));
            id_valid     = (c >= 5) && ($urandom_range(0, 3) != 0);
            flush        = (c >= 5) && ($urandom_range(0, 9) == 0);
            id_rs        = rnd_reg();
            id_rt        = rnd_reg();
            id_rd        = rnd_reg();
            id_rt_used   = 1'($urandom_range(0, 1));
            id_rd1       = $urandom;
            id_rd2       = $urandom;
            id_imm32     = $urandom;
            id_sha32     = DW'($urandom_range(0, 31));
            id_alusrc    = 2'($urandom_range(0, 3));
            id_regdst    = 2'($urandom_range(0, 3));
            id_regwrite  = 1'($urandom_range(0, 1));
            id_memread   = ($urandom_range(0, 2) == 0);
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_a3       = rnd_reg();
            mem_result   = $urandom;
            wb_regwrite  = 1'($urandom_range(0, 1));
            wb_a3        = rnd_reg();
            wb_rfwd      = $urandom;
            if (c < 3) begin
                mem_regwrite = 0;
                wb_regwrite  = 0;
            end

            if (!rstn) cur = bubble();

            // Expected view of EX during this cycle.
            hz = cur.valid && cur.memread && cur.a3 != 0 && id_valid &&
                 (cur.a3 == id_rs || (id_rt_used && cur.a3 == id_rt));
            e.stall    = hz;
            e.valid    = cur.valid;
            e.regwrite = cur.regwrite;
            e.memread  = cur.memread;
            e.a3       = cur.a3;
            e.a        = newest(cur.rs, cur.rs_val, 1'b1);
            e.sd       = newest(cur.rt, cur.rt_val, 1'b1);
            case (cur.alusrc)
                2'd0:    e.b = e.sd;
                2'd1:    e.b = cur.imm;
                2'd2:    e.b = cur.sha;
                default: e.b = '0;
            endcase
            sb.push_back(e);

            // What the next rising edge moves into EX.
            if (!rstn || flush || hz) begin
                nxt = bubble();
            end else begin
                nxt.valid    = id_valid;
                nxt.regwrite = id_valid && id_regwrite;
                nxt.memread  = id_valid && id_memread;
                nxt.a3       = (id_regdst == 2'd1) ? id_rd :
                               (id_regdst == 2'd2) ? AW'(31) : id_rt;
                nxt.rs       = id_rs;
                nxt.rt       = id_rt;
                nxt.rs_val   = newest(id_rs, id_rd1, 1'b0);
                nxt.rt_val   = newest(id_rt, id_rd2, 1'b0);
                nxt.imm      = id_imm32;
                nxt.sha      = id_sha32;
                nxt.alusrc   = id_alusrc;
            end
            cur = nxt;
        end
        repeat (3) @(negedge clk);
        #4;
        check("scoreboard_drained", DW'(sb.size()), DW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
